psum_ofifo: RTL and testbench
=============================

// Module: psum_ofifo
// PURPOSE
//  Output FIFO between the MAC array and the per-column sfp stage.
//  Each array column writes psums independently, when its own valid fires. Columns may be skewed by several cycles.
//  The block aligns the columns, so one row of col psums is released only when every column holds data.
//  The consumer (sfp accumulate/relu sequencer) pops one whole row per read.
// PARAMETERS
//  col      8   number of array columns / independent column FIFOs
//  psum_bw  16  width of one psum entry
//  depth    64  entries per column FIFO; power of two, >= 2
// PORTS
//  clk        in   1             single clock; all flops rise-edge
//  reset      in   1             asynchronous, active-low reset (0 = reset)
//  in         in   col*psum_bw   column c data at [c*psum_bw +: psum_bw]
//  wr         in   col           per-column write strobe
//  rd         in   1             pop one entry from every column
//  out        out  col*psum_bw   registered row; column c at [c*psum_bw +: psum_bw]
//  o_valid    out  1             every column non-empty (a row is available)
//  o_full     out  1             at least one column is full
//  o_ready    out  1             ~o_full; the array stalls on 0
//  o_ovf      out  1             sticky: a write hit a full column
//  o_udf      out  1             sticky: rd asserted while o_valid=0
// BEHAVIOUR
//  - Reset (reset=0, async): pointers=0, out=0, all flags=0; storage RAM is not reset.
//  - Each column is a circular buffer with wr_ptr and rd_ptr, each $clog2(depth)+1 bits.
//    - Empty: ptrs equal.
//    - Full: low bits equal and MSB differs.
//    - Pointers wrap naturally at 2*depth.
//  - Write column c: if wr[c] and column c is not full (pre-edge state), then store in[c] at wr_ptr and increment wr_ptr.
//    - wr[c] on a full column: data dropped, pointer unchanged, o_ovf<=1.
//  - Read: if rd and o_valid (pre-edge), every column's rd_ptr increments together.
//    - out <= head entry of each column, visible the cycle after the rd edge (1-cycle latency).
//    - out holds its value on all other cycles.
//  - rd while o_valid=0: ignored, no pointer change, o_udf<=1.
//  - Simultaneous write and read on one column: both take effect and occupancy is unchanged.
//    - Fullness is evaluated pre-edge, so a write to a full column is dropped even if rd pops it in the same cycle.
//  - o_valid, o_full and o_ready are combinational from pointers only, never from in/wr/rd.
//  - The sticky flags o_ovf and o_udf clear only on reset.
//  - Reset asserted mid-operation: all contents are logically discarded at once; o_valid=0 while reset is held.
//  - Column psums are stored bit-exact; no sign extension and no arithmetic.
// STRUCTURE
//  - Shared package/header: default COL=8, PSUM_BW=16, OFIFO_DEPTH=64; the same values are used by the array and sfp instances.
//  - Sub-module fifo_column: one circular buffer column.
//    - Parameters: psum_bw, depth.
//    - Ports: wr, rd_en, din, dout(head), empty, full.
//  - psum_ofifo instantiates fifo_column col times via generate.
//  - The parent holds the row-valid AND, the full OR, the out register and the sticky flags.
// TESTING
//  1 Reset, then one write per column with in[c]=c+1, then rd.
//    -> o_valid=1 after the last write; out={8..1} one cycle after rd; o_valid=0 afterwards.
//  2 Skew: column 0 written at cycle 0, column 7 at cycle 5, others in between.
//    -> o_valid stays 0 until the cycle after column 7's write.
//  3 Fill column 3 with 64 writes.
//    -> o_full=1 and o_ready=0; a 65th write sets o_ovf=1; contents are unchanged.
//  4 Stream 200 rows with rd every cycle while writing.
//    -> output order matches input order across pointer wrap; no flag set.
//  5 rd while empty -> o_udf=1, out holds its previous value.
//    Assert reset=0 mid-stream -> o_valid=0 and out=0 immediately (async).
//  6 Full column gets wr and rd in the same cycle.
//    -> read succeeds, write dropped, o_ovf=1, occupancy becomes depth-1.

Source files
------------

// File: rtl/psum_ofifo_pkg.sv
// Shared sizing for the MAC array output FIFO; the array and sfp stages
// are built from the same values so row widths always line up.
package psum_ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/psum_ofifo_if.sv
// Row-oriented bus between the MAC array / sfp sequencer and the output FIFO.
// The master side writes column psums and pops rows; the slave is the FIFO.
interface psum_ofifo_if #(
  parameter int col     = psum_ofifo_pkg::COL,
  parameter int psum_bw = psum_ofifo_pkg::PSUM_BW
);
  import psum_ofifo_pkg::*;

  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_ovf;
  logic                   o_udf;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, o_ovf, o_udf
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, o_ovf, o_udf
  );

endinterface

// File: rtl/psum_ofifo_fifo_column.sv
// One column of the output FIFO: a circular buffer whose head entry is
// always visible on dout. Writes into a full column are silently dropped;
// the parent decides when a pop is legal and drives rd_en accordingly.
module fifo_column #(
  parameter int psum_bw = psum_ofifo_pkg::PSUM_BW,
  parameter int depth   = psum_ofifo_pkg::OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic               rd_en,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);
  import psum_ofifo_pkg::*;

  localparam int AW = $clog2(depth);
  localparam int PW = ptr_width(depth);

  logic [psum_bw-1:0] mem [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               wr_fire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_fire = wr && !full;
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  // Advance pointers; fullness is judged on the pre-edge state only
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en)   rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers, cleared asynchronously so contents vanish on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO between the MAC array and the sfp stage. Columns fill
// independently (skewed), and a row is released only when every column
// holds data; a pop takes one entry from every column into a registered row.
module psum_ofifo #(
  parameter int col     = psum_ofifo_pkg::COL,
  parameter int psum_bw = psum_ofifo_pkg::PSUM_BW,
  parameter int depth   = psum_ofifo_pkg::OFIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  psum_ofifo_if.slave      bus
);
  import psum_ofifo_pkg::*;

  logic [col-1:0]         col_empty;
  logic [col-1:0]         col_full;
  logic [col*psum_bw-1:0] head_row;
  logic [col*psum_bw-1:0] out_q, out_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   row_valid;
  logic                   rd_fire;

  assign row_valid = ~|col_empty;
  assign rd_fire   = bus.rd && row_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    fifo_column #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk   (clk),
      .rst_n (reset),
      .wr    (bus.wr[c]),
      .rd_en (rd_fire),
      .din   (bus.in[c*psum_bw +: psum_bw]),
      .dout  (head_row[c*psum_bw +: psum_bw]),
      .empty (col_empty[c]),
      .full  (col_full[c])
    );
  end

  // Capture the head row on a legal pop and latch overflow/underflow events
  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (rd_fire)                 out_d = head_row;
    if (|(bus.wr & col_full))    ovf_d = 1'b1;
    if (bus.rd && !row_valid)    udf_d = 1'b1;
  end

  // Output row and sticky flags; only reset clears the flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.o_valid = row_valid;
  assign bus.o_full  = |col_full;
  assign bus.o_ready = ~|col_full;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_udf   = udf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo with hand-computed rows.
module tb_psum_ofifo;

  localparam int COLS = 8;
  localparam int BW   = 16;
  localparam int DEP  = 64;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [COLS*BW-1:0] exp_row;

  psum_ofifo_if #(.col(COLS), .psum_bw(BW)) bus_if ();

  psum_ofifo #(.col(COLS), .psum_bw(BW), .depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row whose column c holds base + step*c
  function automatic logic [COLS*BW-1:0] mk_row(input int base, input int step);
    logic [COLS*BW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*BW +: BW] = 16'(base + step*c);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.wr = '0;
    bus_if.rd = 1'b0;
    bus_if.in = '0;
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus_if.wr = '0;
    bus_if.rd = 1'b0;
    bus_if.in = '0;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus_if.o_valid); end
    checks++; if (bus_if.o_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", bus_if.o_full); end
    checks++; if (bus_if.o_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus_if.o_ready); end
    checks++; if (bus_if.out !== '0) begin failures++; $display("[TB] FAIL reset_out got=%h exp=0", bus_if.out); end
    checks++; if ({bus_if.o_ovf, bus_if.o_udf} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00", {bus_if.o_ovf, bus_if.o_udf}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_row();
    for (int c = 0; c < COLS; c++) begin
      bus_if.wr = 8'(1 << c);
      bus_if.in = '0;
      bus_if.in[c*BW +: BW] = 16'(c + 1);
      tick();
      if (c < COLS-1) begin
        checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_early c=%0d got=%b exp=0", c, bus_if.o_valid); end
      end
    end
    bus_if.wr = '0;
    checks++; if (bus_if.o_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", bus_if.o_valid); end
    bus_if.rd = 1'b1;
    tick();
    bus_if.rd = 1'b0;
    exp_row = mk_row(1, 1);
    checks++; if (bus_if.out !== exp_row) begin failures++; $display("[TB] FAIL single_out got=%h exp=%h", bus_if.out, exp_row); end
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_after got=%b exp=0", bus_if.o_valid); end
    tick();
    checks++; if (bus_if.out !== exp_row) begin failures++; $display("[TB] FAIL single_out_hold got=%h exp=%h", bus_if.out, exp_row); end
  endtask

  task automatic test_skew();
    int wcyc [COLS] = '{0, 1, 2, 3, 4, 4, 4, 5};
    bus_if.in = mk_row(16'h100, 1);
    for (int cyc = 0; cyc <= 5; cyc++) begin
      for (int c = 0; c < COLS; c++) bus_if.wr[c] = (wcyc[c] == cyc);
      tick();
      checks++;
      if (bus_if.o_valid !== (cyc == 5)) begin failures++; $display("[TB] FAIL skew_valid cyc=%0d got=%b exp=%b", cyc, bus_if.o_valid, (cyc == 5)); end
    end
    bus_if.wr = '0;
    bus_if.rd = 1'b1;
    tick();
    bus_if.rd = 1'b0;
    exp_row = mk_row(16'h100, 1);
    checks++; if (bus_if.out !== exp_row) begin failures++; $display("[TB] FAIL skew_out got=%h exp=%h", bus_if.out, exp_row); end
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL skew_valid_after got=%b exp=0", bus_if.o_valid); end
  endtask

  task automatic test_fill();
    int bad;
    do_reset();
    bus_if.wr = 8'h08;
    for (int i = 0; i < DEP; i++) begin
      bus_if.in[3*BW +: BW] = 16'(16'h3000 + i);
      tick();
      if (i == DEP-2) begin
        checks++; if (bus_if.o_full !== 1'b0) begin failures++; $display("[TB] FAIL fill_full_early got=%b exp=0", bus_if.o_full); end
      end
    end
    checks++; if (bus_if.o_full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%b exp=1", bus_if.o_full); end
    checks++; if (bus_if.o_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready got=%b exp=0", bus_if.o_ready); end
    checks++; if (bus_if.o_ovf !== 1'b0) begin failures++; $display("[TB] FAIL fill_ovf_early got=%b exp=0", bus_if.o_ovf); end
    bus_if.in[3*BW +: BW] = 16'hDEAD;
    tick();
    checks++; if (bus_if.o_ovf !== 1'b1) begin failures++; $display("[TB] FAIL fill_ovf got=%b exp=1", bus_if.o_ovf); end
    bus_if.wr = 8'hF7;
    for (int i = 0; i < DEP; i++) begin
      bus_if.in = mk_row(16'h0A00 + i, 0);
      tick();
    end
    bus_if.wr = '0;
    bad = 0;
    bus_if.rd = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      tick();
      exp_row = mk_row(16'h0A00 + i, 0);
      exp_row[3*BW +: BW] = 16'(16'h3000 + i);
      if (bus_if.out !== exp_row) begin
        bad++;
        if (bad == 1) $display("[TB] FAIL fill_contents row=%0d got=%h exp=%h", i, bus_if.out, exp_row);
      end
    end
    bus_if.rd = 1'b0;
    checks++; if (bad != 0) failures++;
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL fill_drained_valid got=%b exp=0", bus_if.o_valid); end
  endtask

  task automatic test_full_rw();
    int bad;
    do_reset();
    bus_if.wr = 8'h08;
    for (int i = 0; i < DEP; i++) begin
      bus_if.in[3*BW +: BW] = 16'(16'h6000 + i);
      tick();
    end
    bus_if.wr = 8'hF7;
    bus_if.in = mk_row(16'h0B00, 0);
    tick();
    checks++; if ({bus_if.o_valid, bus_if.o_full, bus_if.o_ovf} !== 3'b110) begin failures++; $display("[TB] FAIL rw_pre got=%b exp=110", {bus_if.o_valid, bus_if.o_full, bus_if.o_ovf}); end
    bus_if.wr = 8'h08;
    bus_if.in[3*BW +: BW] = 16'hBEEF;
    bus_if.rd = 1'b1;
    tick();
    bus_if.wr = '0;
    bus_if.rd = 1'b0;
    exp_row = mk_row(16'h0B00, 0);
    exp_row[3*BW +: BW] = 16'h6000;
    checks++; if (bus_if.out !== exp_row) begin failures++; $display("[TB] FAIL rw_out got=%h exp=%h", bus_if.out, exp_row); end
    checks++; if (bus_if.o_ovf !== 1'b1) begin failures++; $display("[TB] FAIL rw_ovf got=%b exp=1", bus_if.o_ovf); end
    checks++; if (bus_if.o_full !== 1'b0) begin failures++; $display("[TB] FAIL rw_full got=%b exp=0", bus_if.o_full); end
    bus_if.wr = 8'hF7;
    for (int i = 1; i < DEP; i++) begin
      bus_if.in = mk_row(16'h0C00 + i, 0);
      tick();
    end
    bus_if.wr = '0;
    bad = 0;
    bus_if.rd = 1'b1;
    for (int i = 1; i < DEP; i++) begin
      tick();
      exp_row = mk_row(16'h0C00 + i, 0);
      exp_row[3*BW +: BW] = 16'(16'h6000 + i);
      if (bus_if.out !== exp_row) begin
        bad++;
        if (bad == 1) $display("[TB] FAIL rw_contents row=%0d got=%h exp=%h", i, bus_if.out, exp_row);
      end
    end
    bus_if.rd = 1'b0;
    checks++; if (bad != 0) failures++;
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL rw_occupancy got_valid=%b exp=0", bus_if.o_valid); end
    checks++; if (bus_if.o_udf !== 1'b0) begin failures++; $display("[TB] FAIL rw_udf got=%b exp=0", bus_if.o_udf); end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k <= 200; k++) begin
      if (k < 200) begin
        bus_if.wr = 8'hFF;
        bus_if.in = mk_row(k*8, 1);
      end else begin
        bus_if.wr = '0;
      end
      bus_if.rd = (k > 0);
      tick();
      if (k > 0) begin
        exp_row = mk_row((k-1)*8, 1);
        if (bus_if.out !== exp_row) begin
          bad++;
          if (bad == 1) $display("[TB] FAIL stream_out row=%0d got=%h exp=%h", k-1, bus_if.out, exp_row);
        end
      end
    end
    bus_if.rd = 1'b0;
    checks++; if (bad != 0) failures++;
    checks++; if ({bus_if.o_valid, bus_if.o_full, bus_if.o_ovf, bus_if.o_udf} !== 4'b0000) begin failures++; $display("[TB] FAIL stream_flags got=%b exp=0000", {bus_if.o_valid, bus_if.o_full, bus_if.o_ovf, bus_if.o_udf}); end
  endtask

  task automatic test_underflow_reset();
    exp_row = mk_row(199*8, 1);
    bus_if.rd = 1'b1;
    tick();
    bus_if.rd = 1'b0;
    checks++; if (bus_if.o_udf !== 1'b1) begin failures++; $display("[TB] FAIL udf_flag got=%b exp=1", bus_if.o_udf); end
    checks++; if (bus_if.out !== exp_row) begin failures++; $display("[TB] FAIL udf_out_hold got=%h exp=%h", bus_if.out, exp_row); end
    bus_if.wr = 8'hFF;
    bus_if.in = mk_row(16'h5500, 3);
    tick();
    tick();
    bus_if.wr = '0;
    bus_if.rd = 1'b1;
    tick();
    bus_if.rd = 1'b0;
    exp_row = mk_row(16'h5500, 3);
    checks++; if ({bus_if.o_valid, bus_if.out} !== {1'b1, exp_row}) begin failures++; $display("[TB] FAIL midrst_pre got=%b/%h exp=1/%h", bus_if.o_valid, bus_if.out, exp_row); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", bus_if.o_valid); end
    checks++; if (bus_if.out !== '0) begin failures++; $display("[TB] FAIL midrst_out got=%h exp=0", bus_if.out); end
    checks++; if ({bus_if.o_udf, bus_if.o_ovf, bus_if.o_ready} !== 3'b001) begin failures++; $display("[TB] FAIL midrst_flags got=%b exp=001", {bus_if.o_udf, bus_if.o_ovf, bus_if.o_ready}); end
    tick();
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_hold_valid got=%b exp=0", bus_if.o_valid); end
    reset = 1'b1;
    tick();
    checks++; if (bus_if.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL postrst_valid got=%b exp=0", bus_if.o_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    test_reset();
    test_single_row();
    test_skew();
    test_fill();
    test_full_rw();
    test_back_to_back();
    test_underflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
